branch_predictor: RTL and testbench
===================================

# branch_predictor

- Fetch-stage branch target buffer with 2-bit saturating direction counters.
- Consumes the branch resolution produced in EX: resolved outcome, actual target, and the prediction that travelled down the pipe.
- Produces a next-PC prediction for IF every cycle.
- Detects mispredictions and drives the redirect PC and flush request back to fetch.

## Interface

Parameters:
- IDX_W, 4: index width; table holds 2**IDX_W entries.
- PC_W, 32: PC and target width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  PC_W  fetch PC to look up.
- pred_taken  out  1  fetch should take the predicted branch.
- pred_target  out  PC_W  predicted target; 0 when pred_taken=0.
- ex_valid  in  1  a conditional branch resolves in EX this cycle (the decoded Branch qualified by EX-stage valid).
- ex_pc  in  PC_W  PC of the resolving branch.
- ex_taken  in  1  resolved outcome (branch-control output).
- ex_target  in  PC_W  computed branch target.
- ex_pred_taken  in  1  pred_taken carried with this instruction from IF.
- ex_pred_target  in  PC_W  pred_target carried with this instruction from IF.
- mispredict  out  1  redirect and flush IF/ID this cycle.
- redirect_pc  out  PC_W  correct next PC when mispredict=1.
- stat_branches  out  32  resolved branch count (only with BP_STATS_EN).
- stat_mispredicts  out  32  mispredict count (only with BP_STATS_EN).

## Operation

- Entry fields: valid, tag, target, 2-bit counter ctr.
- Index is pc[IDX_W+1:2]; tag is pc[PC_W-1:IDX_W+2].
- PC bits [1:0] are ignored.
- Lookup:
  - hit = valid[idx] && tag[idx] == if_pc tag.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target : 0.
- Update (when ex_valid=1, clocked):
  - Hit, ex_taken=1: ctr saturating +1, capped at 2'b11; target <= ex_target.
  - Hit, ex_taken=0: ctr saturating -1, floored at 2'b00; target unchanged.
  - Miss, ex_taken=1: allocate the entry (overwrite any occupant). valid=1, tag from ex_pc, target=ex_target, ctr=2'b10 (weakly taken).
  - Miss, ex_taken=0: no change.
- Mispredict (combinational) = ex_valid && ((ex_taken != ex_pred_taken) || (ex_taken && ex_pred_taken && ex_target != ex_pred_target)).
- redirect_pc:
  - ex_taken ? ex_target : ex_pc + 4 (modulo 2**PC_W; wrap at the top of the address space).
  - Equals ex_pc + 4 whenever mispredict=0 (don't-care for consumers).
- When ex_valid=0: mispredict=0, and the table and statistics do not change.

## Timing

- Lookup latency 0: pred_* is combinational from if_pc and the current table state.
- Update latency 1: writes land on the rising edge following ex_valid=1 and are visible to lookup from the next cycle.
- Same-cycle update and lookup to the same index: lookup returns the pre-update contents. No bypass.
- mispredict and redirect_pc are combinational in the EX cycle. The table update still happens on the mispredicting branch.
- Reset, asserted at any time, including mid-update:
  - All valid bits clear immediately, so pred_taken=0 and pred_target=0.
  - mispredict depends only on ex_* inputs.
  - Statistics reset to 0.
  - Tag, target and ctr need no reset.
- Counter saturation holds under back-to-back updates every cycle.

## Configuration

- BP_STATS_EN defined:
  - stat_branches increments on every ex_valid cycle.
  - stat_mispredicts increments on every mispredict cycle.
  - Both saturate at 32'hFFFFFFFF.
  - Both are registered: a count is visible the cycle after the event.
- BP_STATS_EN undefined: stat_* ports are absent and there are no counter flops.

## Test plan

- Reset then lookup: rst_n low, then high; if_pc=0x100 -> pred_taken=0, pred_target=0.
- Cold taken branch:
  - Stimulus: ex_valid=1, ex_pc=0x100, ex_taken=1, ex_target=0x40, ex_pred_taken=0.
  - Same cycle: mispredict=1, redirect_pc=0x40.
  - Next cycle: if_pc=0x100 -> pred_taken=1, pred_target=0x40.
- Counter hysteresis:
  - Entry 0x100 at ctr=2'b10. Resolve not-taken once -> pred_taken=0 for 0x100.
  - Resolve taken twice, then not-taken once -> pred_taken=1 (ctr=2'b10).
  - Resolve not-taken at ctr=2'b00 -> stays 2'b00.
- Target mismatch:
  - Stimulus: ex_taken=1, ex_pred_taken=1, ex_pred_target=0x40, ex_target=0x80.
  - Response: mispredict=1, redirect_pc=0x80; entry target becomes 0x80.
- Alias and fall-through:
  - With IDX_W=4, 0x100 and 0x140 share index 0; resolving taken at 0x140 evicts 0x100, so lookup of 0x100 returns pred_taken=0.
  - Not-taken mispredict at ex_pc=0xFFFFFFFC -> redirect_pc=0x00000000.
  - Same-cycle update and lookup of one index -> old value returned.
- BP_STATS_EN: 10 resolved branches with 3 mispredicts -> stat_branches=10, stat_mispredicts=3 one cycle after the last; reset mid-run clears both to 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Branch predictor port bundle: fetch-side lookup, EX-side resolution,
// and the redirect/flush response back to fetch.
// master = pipeline side, slave = predictor.
interface branch_predictor_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] if_pc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  logic            ex_pred_taken;
  logic [PC_W-1:0] ex_pred_target;
  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-stage branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from if_pc; EX resolutions update the table on the
// next rising edge (no bypass). Mispredict/redirect are combinational in EX.
// Optional feature macro: BP_STATS_EN adds saturating resolved-branch and
// mispredict counters (stat_branches / stat_mispredicts).
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int PC_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_predictor_if.slave    bp
`ifdef BP_STATS_EN
  ,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
`endif
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [PC_W-1:0]  target_q [DEPTH];
  logic [1:0]       ctr_q    [DEPTH];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             pred_taken_c;
  logic             mispredict_c;

  // Word-aligned PCs: the byte-offset bits never participate in lookup.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^bp.if_pc[1:0];

  assign if_idx = bp.if_pc[IDX_W+1:2];
  assign if_tag = bp.if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = bp.ex_pc[IDX_W+1:2];
  assign ex_tag = bp.ex_pc[PC_W-1:IDX_W+2];

  // Fetch lookup against current table contents (pre-update on same-cycle writes).
  always_comb begin
    if_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken_c = if_hit && ctr_q[if_idx][1];
  end

  assign bp.pred_taken  = pred_taken_c;
  assign bp.pred_target = pred_taken_c ? target_q[if_idx] : '0;

  // EX resolution: wrong direction, or right direction but wrong taken target.
  always_comb begin
    ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    mispredict_c = bp.ex_valid &&
                   ((bp.ex_taken != bp.ex_pred_taken) ||
                    (bp.ex_taken && bp.ex_pred_taken && (bp.ex_target != bp.ex_pred_target)));
  end

  // Fall-through is the default redirect so the bus is stable when not flushing.
  assign bp.mispredict  = mispredict_c;
  assign bp.redirect_pc = (mispredict_c && bp.ex_taken) ? bp.ex_target : bp.ex_pc + PC_W'(4);

  // Valid bits: only these need reset; a taken miss allocates the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (bp.ex_valid && !ex_hit && bp.ex_taken) begin
      valid_q[ex_idx] <= 1'b1;
    end
  end

  // Entry payload update: counter training on hits, fresh allocation on taken misses.
  always_ff @(posedge clk) begin
    if (bp.ex_valid) begin
      if (ex_hit) begin
        if (bp.ex_taken) begin
          if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
          target_q[ex_idx] <= bp.ex_target;
        end else begin
          if (ctr_q[ex_idx] != 2'b00) ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
        end
      end else if (bp.ex_taken) begin
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= bp.ex_target;
        ctr_q[ex_idx]    <= 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  // Saturating event counters, visible the cycle after the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (bp.ex_valid && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (mispredict_c && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (IDX_W=4, PC_W=32).
// Each vector occupies one clock: inputs are driven just after a rising edge,
// outputs are checked on the falling edge, and the update lands on the next edge.
module tb_branch_predictor;

  logic clk;
  logic rst_n;

  branch_predictor_if #(.PC_W(32)) bp_if ();

`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predictor #(.IDX_W(4), .PC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [31:0] epc;
    logic        et;
    logic [31:0] etgt;
    logic        ept;
    logic [31:0] eptgt;
    logic [31:0] ipc;
    logic        xpt;
    logic [31:0] xtgt;
    logic        xmp;
    logic [31:0] xred;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs [NVEC];

  int n_applied;
  int n_miscompares;

  function automatic vec_t mk(logic ev, logic [31:0] epc, logic et, logic [31:0] etgt,
                              logic ept, logic [31:0] eptgt, logic [31:0] ipc,
                              logic xpt, logic [31:0] xtgt, logic xmp, logic [31:0] xred);
    vec_t v;
    v.ev = ev; v.epc = epc; v.et = et; v.etgt = etgt; v.ept = ept; v.eptgt = eptgt;
    v.ipc = ipc; v.xpt = xpt; v.xtgt = xtgt; v.xmp = xmp; v.xred = xred;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_applied++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s [%0d]: got 0x%08h, want 0x%08h", nm, idx, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bp_if.ex_valid       = v.ev;
    bp_if.ex_pc          = v.epc;
    bp_if.ex_taken       = v.et;
    bp_if.ex_target      = v.etgt;
    bp_if.ex_pred_taken  = v.ept;
    bp_if.ex_pred_target = v.eptgt;
    bp_if.if_pc          = v.ipc;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    chk("pred_taken",  idx, {31'd0, bp_if.pred_taken}, {31'd0, v.xpt});
    chk("pred_target", idx, bp_if.pred_target,          v.xtgt);
    chk("mispredict",  idx, {31'd0, bp_if.mispredict},  {31'd0, v.xmp});
    chk("redirect_pc", idx, bp_if.redirect_pc,          v.xred);
  endtask

  task automatic idle_inputs();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    n_applied     = 0;
    n_miscompares = 0;
    rst_n         = 1'b0;
    idle_inputs();

    //                ev epc          et etgt        ept eptgt       ipc          xpt xtgt      xmp xred
    vecs[0]  = mk(0, 32'h0,        0, 32'h0,     0, 32'h0,    32'h100,     0, 32'h0,    0, 32'h4);
    vecs[1]  = mk(1, 32'h100,      1, 32'h40,    0, 32'h0,    32'h100,     0, 32'h0,    1, 32'h40);
    vecs[2]  = mk(0, 32'h100,      0, 32'h0,     0, 32'h0,    32'h100,     1, 32'h40,   0, 32'h104);
    vecs[3]  = mk(1, 32'h100,      0, 32'h40,    1, 32'h40,   32'h100,     1, 32'h40,   1, 32'h104);
    vecs[4]  = mk(0, 32'h100,      0, 32'h0,     0, 32'h0,    32'h100,     0, 32'h0,    0, 32'h104);
    vecs[5]  = mk(1, 32'h100,      1, 32'h40,    0, 32'h0,    32'h100,     0, 32'h0,    1, 32'h40);
    vecs[6]  = mk(1, 32'h100,      1, 32'h40,    1, 32'h40,   32'h100,     1, 32'h40,   0, 32'h104);
    vecs[7]  = mk(1, 32'h100,      0, 32'h40,    1, 32'h40,   32'h100,     1, 32'h40,   1, 32'h104);
    vecs[8]  = mk(0, 32'h100,      0, 32'h0,     0, 32'h0,    32'h100,     1, 32'h40,   0, 32'h104);
    vecs[9]  = mk(1, 32'h100,      0, 32'h40,    1, 32'h40,   32'h100,     1, 32'h40,   1, 32'h104);
    vecs[10] = mk(1, 32'h100,      0, 32'h40,    0, 32'h0,    32'h100,     0, 32'h0,    0, 32'h104);
    vecs[11] = mk(1, 32'h100,      0, 32'h40,    0, 32'h0,    32'h100,     0, 32'h0,    0, 32'h104);
    vecs[12] = mk(1, 32'h100,      1, 32'h40,    0, 32'h0,    32'h100,     0, 32'h0,    1, 32'h40);
    vecs[13] = mk(1, 32'h100,      1, 32'h40,    0, 32'h0,    32'h100,     0, 32'h0,    1, 32'h40);
    vecs[14] = mk(1, 32'h100,      1, 32'h40,    1, 32'h40,   32'h100,     1, 32'h40,   0, 32'h104);
    vecs[15] = mk(1, 32'h100,      1, 32'h40,    1, 32'h40,   32'h100,     1, 32'h40,   0, 32'h104);
    vecs[16] = mk(1, 32'h100,      0, 32'h40,    1, 32'h40,   32'h100,     1, 32'h40,   1, 32'h104);
    vecs[17] = mk(0, 32'h100,      0, 32'h0,     0, 32'h0,    32'h100,     1, 32'h40,   0, 32'h104);
    vecs[18] = mk(1, 32'h100,      1, 32'h80,    1, 32'h40,   32'h100,     1, 32'h40,   1, 32'h80);
    vecs[19] = mk(0, 32'h100,      0, 32'h0,     0, 32'h0,    32'h100,     1, 32'h80,   0, 32'h104);
    vecs[20] = mk(1, 32'h140,      1, 32'h200,   0, 32'h0,    32'h100,     1, 32'h80,   1, 32'h200);
    vecs[21] = mk(0, 32'h140,      0, 32'h0,     0, 32'h0,    32'h100,     0, 32'h0,    0, 32'h144);
    vecs[22] = mk(0, 32'h140,      0, 32'h0,     0, 32'h0,    32'h140,     1, 32'h200,  0, 32'h144);
    vecs[23] = mk(1, 32'hFFFFFFFC, 0, 32'h10,    1, 32'h10,   32'hFFFFFFFC, 0, 32'h0,   1, 32'h0);
    vecs[24] = mk(0, 32'hFFFFFFFC, 0, 32'h0,     0, 32'h0,    32'hFFFFFFFC, 0, 32'h0,   0, 32'h0);
    vecs[25] = mk(1, 32'h204,      1, 32'h300,   0, 32'h0,    32'h204,     0, 32'h0,    1, 32'h300);
    vecs[26] = mk(0, 32'h204,      0, 32'h0,     0, 32'h0,    32'h204,     1, 32'h300,  0, 32'h208);
    vecs[27] = mk(0, 32'h204,      0, 32'h0,     0, 32'h0,    32'h207,     1, 32'h300,  0, 32'h208);
    vecs[28] = mk(0, 32'h204,      1, 32'h999,   0, 32'h0,    32'h204,     1, 32'h300,  0, 32'h208);
    vecs[29] = mk(0, 32'h204,      0, 32'h0,     0, 32'h0,    32'h204,     1, 32'h300,  0, 32'h208);
    vecs[30] = mk(1, 32'h300,      0, 32'h50,    0, 32'h60,   32'h140,     1, 32'h200,  0, 32'h304);

    #2;
    do_reset();

    for (int i = 0; i < NVEC; i++) apply(vecs[i], i);

    // Reset asserted mid-cycle while a hit update is pending on 0x204.
    @(posedge clk);
    #1;
    drive(mk(1, 32'h204, 0, 32'h0, 1, 32'h300, 32'h204, 0, 32'h0, 0, 32'h0));
    #1;
    chk("pre_rst_pred_taken", 100, {31'd0, bp_if.pred_taken}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_pred_taken",  101, {31'd0, bp_if.pred_taken}, 32'd0);
    chk("rst_pred_target", 102, bp_if.pred_target,          32'h0);
    chk("rst_mispredict",  103, {31'd0, bp_if.mispredict},  32'd1);
    chk("rst_redirect_pc", 104, bp_if.redirect_pc,          32'h208);
    @(posedge clk);
    #1;
    idle_inputs();
    bp_if.if_pc = 32'h140;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_pred_taken", 105, {31'd0, bp_if.pred_taken}, 32'd0);
    apply(mk(1, 32'h204, 1, 32'h500, 0, 32'h0, 32'h204, 0, 32'h0, 1, 32'h500), 106);
    apply(mk(0, 32'h204, 0, 32'h0,   0, 32'h0, 32'h204, 1, 32'h500, 0, 32'h208), 107);

`ifdef BP_STATS_EN
    do_reset();
    @(negedge clk);
    chk("stat_branches_rst",    200, stat_branches,    32'd0);
    chk("stat_mispredicts_rst", 201, stat_mispredicts, 32'd0);
    // 10 resolutions; i = 0, 3, 6 are taken-but-predicted-not-taken.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      bp_if.ex_valid       = 1'b1;
      bp_if.ex_pc          = 32'h400 + 32'(i * 4);
      bp_if.ex_taken       = ((i % 3) == 0) && (i < 9);
      bp_if.ex_target      = 32'h800;
      bp_if.ex_pred_taken  = 1'b0;
      bp_if.ex_pred_target = 32'h0;
    end
    @(negedge clk);
    chk("stat_branches_9",    202, stat_branches,    32'd9);
    chk("stat_mispredicts_3", 203, stat_mispredicts, 32'd3);
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    chk("stat_branches_10",   204, stat_branches,    32'd10);
    chk("stat_mispredicts_3b", 205, stat_mispredicts, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("stat_branches_clr",    206, stat_branches,    32'd0);
    chk("stat_mispredicts_clr", 207, stat_mispredicts, 32'd0);
    #1;
    rst_n = 1'b1;
`endif

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
